// File: rtl/aud_pkg.sv
// Shared audio codec constants and state encoding for the playback and capture paths.
package aud_pkg;

  localparam int unsigned AUD_CLK_DIV = 48;
  localparam int unsigned SLOT_BITS   = 16;
  localparam int unsigned FRAME_BITS  = 32;
  localparam int unsigned BIT_CNT_W   = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_PLAY  = 2'd2
  } aud_state_e;

endpackage

// File: rtl/aud_bclk_gen.sv
// Divides MCLK down to the codec bit clock; fall_tick marks the MCLK edge on which BCLK falls.
module aud_bclk_gen
  import aud_pkg::*;
#(
  parameter int unsigned CLK_DIV = AUD_CLK_DIV
) (
  input  logic MCLK,
  input  logic reset,
  output logic AUD_BCLK,
  output logic fall_tick
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned HALF  = CLK_DIV / 2;

  logic [CNT_W-1:0] clk_count;
  logic [CNT_W-1:0] clk_count_d;

  assign fall_tick   = (clk_count == CNT_W'(CLK_DIV - 1));
  assign clk_count_d = fall_tick ? '0 : clk_count + CNT_W'(1);

  // BCLK is registered from the next count so it tracks clk_count exactly
  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      clk_count <= '0;
      AUD_BCLK  <= 1'b0;
    end else begin
      clk_count <= clk_count_d;
      AUD_BCLK  <= (clk_count_d >= CNT_W'(HALF));
    end
  end

endmodule

// File: rtl/aud_out.sv
// Plays a memory range of samples to a codec DAC, left-justified, same sample in both slots.
module aud_out
  import aud_pkg::*;
#(
  parameter int unsigned CLK_DIV = AUD_CLK_DIV,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 18
) (
  input  logic              MCLK,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] AUD_ADDR1,
  input  logic [ADDR_W-1:0] AUD_ADDR2,
  output logic [ADDR_W-1:0] MEM_CURRENT,
  input  logic [DATA_W-1:0] MEM_DATA,
  output logic              AUD_BCLK,
  output logic              AUD_DACLRCK,
  output logic              AUD_DACDAT,
  output logic              done
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(FRAME_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] RIGHT_BIT = BIT_CNT_W'(SLOT_BITS);

  aud_state_e           state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W-1:0]    addr_e_q, addr_e_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]    shift_q, shift_d;
  logic                 lrck_q, lrck_d;
  logic                 dat_q, dat_d;
  logic                 fall_tick;
  logic                 have_sample;
  logic                 load;

  aud_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk_gen (
    .MCLK      (MCLK),
    .reset     (reset),
    .AUD_BCLK  (AUD_BCLK),
    .fall_tick (fall_tick)
  );

  assign have_sample = (addr_q < addr_e_q);
  assign MEM_CURRENT = addr_q;
  assign AUD_DACLRCK = lrck_q;
  assign AUD_DACDAT  = dat_q;
  assign done        = (state_q == ST_READY) && (addr_q == addr_e_q);

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      addr_e_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      lrck_q    <= 1'b1;
      dat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      addr_e_q  <= addr_e_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      lrck_q    <= lrck_d;
      dat_q     <= dat_d;
    end
  end

  // Shift register rotates so the sample is back in place for the right slot
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    addr_e_d  = addr_e_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    lrck_d    = lrck_q;
    dat_d     = dat_q;
    load      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d  = ST_READY;
          addr_d   = AUD_ADDR1;
          addr_e_d = AUD_ADDR2;
        end
      end
      ST_READY: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (fall_tick && have_sample) begin
          state_d = ST_PLAY;
          load    = 1'b1;
        end
      end
      ST_PLAY: begin
        if (fall_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            if (enable && have_sample) begin
              load = 1'b1;
            end else begin
              state_d = ST_READY;
              dat_d   = 1'b0;
              lrck_d  = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            shift_d   = {shift_q[DATA_W-2:0], shift_q[DATA_W-1]};
            dat_d     = shift_q[DATA_W-2];
            lrck_d    = (bit_cnt_d >= RIGHT_BIT);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Sample load: next address becomes stable for the whole frame it precedes
    if (load) begin
      addr_d    = addr_q + ADDR_W'(1);
      bit_cnt_d = '0;
      shift_d   = MEM_DATA;
      dat_d     = MEM_DATA[DATA_W-1];
      lrck_d    = 1'b0;
    end
  end

endmodule

// File: tb/tb_aud_out.sv
// Directed bench for aud_out: bit-clock timing, playback ranges, enable drop, reset abort, top-of-range.
module tb_aud_out;

  localparam int unsigned CLK_DIV = 48;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 18;
  localparam int          BOUND   = 4 * CLK_DIV;

  logic              MCLK;
  logic              reset;
  logic              enable;
  logic [ADDR_W-1:0] AUD_ADDR1;
  logic [ADDR_W-1:0] AUD_ADDR2;
  logic [ADDR_W-1:0] MEM_CURRENT;
  logic [DATA_W-1:0] MEM_DATA;
  logic              AUD_BCLK;
  logic              AUD_DACLRCK;
  logic              AUD_DACDAT;
  logic              done;

  int          n_vec;
  int          n_err;
  int          n;
  logic [15:0] left_w;
  logic [15:0] right_w;
  logic [31:0] lr_w;

  aud_out #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W)
  ) dut (
    .MCLK        (MCLK),
    .reset       (reset),
    .enable      (enable),
    .AUD_ADDR1   (AUD_ADDR1),
    .AUD_ADDR2   (AUD_ADDR2),
    .MEM_CURRENT (MEM_CURRENT),
    .MEM_DATA    (MEM_DATA),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_DACLRCK (AUD_DACLRCK),
    .AUD_DACDAT  (AUD_DACDAT),
    .done        (done)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  // Sample memory: two fixed words, otherwise {addr[7:0], ~addr[7:0]}
  function automatic logic [15:0] mem_rd(input logic [17:0] a);
    case (a)
      18'h00010: mem_rd = 16'hA5C3;
      18'h00011: mem_rd = 16'h0F0F;
      default:   mem_rd = {a[7:0], ~a[7:0]};
    endcase
  endfunction

  assign MEM_DATA = mem_rd(MEM_CURRENT);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge MCLK);
    #1;
  endtask

  task automatic bclk_edge(input logic rise);
    logic prev;
    logic ok;
    prev = AUD_BCLK;
    ok   = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      cyc(1);
      if ((AUD_BCLK == rise) && (prev != rise)) begin
        ok = 1'b1;
        break;
      end
      prev = AUD_BCLK;
    end
    if (!ok) chk(rise ? "bclk_rise_timeout" : "bclk_fall_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_frame_start();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      if (AUD_DACLRCK == 1'b0) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
    if (!ok) chk("frame_start_timeout", 32'(ok), 32'd1);
  endtask

  // Sample DACDAT/LRCK at each BCLK rise, as the codec does
  task automatic collect(input int from, input int to);
    for (int k = from; k <= to; k++) begin
      bclk_edge(1'b1);
      if (k < 16) left_w = {left_w[14:0], AUD_DACDAT};
      else        right_w = {right_w[14:0], AUD_DACDAT};
      lr_w[k] = AUD_DACLRCK;
    end
  endtask

  task automatic level_len(input logic lvl, output int len);
    len = 0;
    while ((AUD_BCLK == lvl) && (len < BOUND)) begin
      cyc(1);
      len++;
    end
  endtask

  task automatic watch_quiet(input int k, input logic [17:0] a, input string tag);
    int bad;
    bad = 0;
    repeat (k) begin
      cyc(1);
      if ((AUD_DACLRCK !== 1'b1) || (AUD_DACDAT !== 1'b0) || (MEM_CURRENT !== a)) bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b0;
    enable    = 1'b0;
    AUD_ADDR1 = '0;
    AUD_ADDR2 = '0;
    left_w    = '0;
    right_w   = '0;
    lr_w      = '0;

    // Reset state and bit-clock timing with enable low
    cyc(3);
    chk("rst_bclk", 32'(AUD_BCLK), 32'd0);
    chk("rst_lrck", 32'(AUD_DACLRCK), 32'd1);
    chk("rst_dat", 32'(AUD_DACDAT), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem", 32'(MEM_CURRENT), 32'd0);
    reset = 1'b1;
    level_len(1'b0, n);
    chk("bclk_first_low", 32'(n), 32'd24);
    level_len(1'b1, n);
    chk("bclk_high", 32'(n), 32'd24);
    level_len(1'b0, n);
    chk("bclk_low", 32'(n), 32'd24);
    chk("idle_lrck", 32'(AUD_DACLRCK), 32'd1);
    chk("idle_dat", 32'(AUD_DACDAT), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    // Two-sample range 0x10..0x12
    AUD_ADDR1 = 18'h10;
    AUD_ADDR2 = 18'h12;
    enable    = 1'b1;
    cyc(1);
    chk("r2_mem_start", 32'(MEM_CURRENT), 32'h10);
    chk("r2_done_start", 32'(done), 32'd0);
    wait_frame_start();
    collect(0, 31);
    chk("r2_f0_left", 32'(left_w), 32'hA5C3);
    chk("r2_f0_right", 32'(right_w), 32'hA5C3);
    chk("r2_f0_lrck", lr_w, 32'hFFFF0000);
    chk("r2_f0_mem", 32'(MEM_CURRENT), 32'h11);
    collect(0, 31);
    chk("r2_f1_left", 32'(left_w), 32'h0F0F);
    chk("r2_f1_right", 32'(right_w), 32'h0F0F);
    chk("r2_f1_lrck", lr_w, 32'hFFFF0000);
    chk("r2_f1_mem", 32'(MEM_CURRENT), 32'h12);
    bclk_edge(1'b0);
    chk("r2_end_done", 32'(done), 32'd1);
    chk("r2_end_lrck", 32'(AUD_DACLRCK), 32'd1);
    chk("r2_end_dat", 32'(AUD_DACDAT), 32'd0);
    chk("r2_end_mem", 32'(MEM_CURRENT), 32'h12);
    enable = 1'b0;
    cyc(1);
    chk("r2_idle_done", 32'(done), 32'd0);

    // Empty and inverted ranges
    AUD_ADDR1 = 18'h20;
    AUD_ADDR2 = 18'h20;
    enable    = 1'b1;
    cyc(1);
    chk("eq_done", 32'(done), 32'd1);
    chk("eq_mem", 32'(MEM_CURRENT), 32'h20);
    watch_quiet(150, 18'h20, "eq_no_play");
    enable = 1'b0;
    cyc(1);
    AUD_ADDR1 = 18'h21;
    AUD_ADDR2 = 18'h20;
    enable    = 1'b1;
    cyc(1);
    chk("inv_done", 32'(done), 32'd0);
    chk("inv_mem", 32'(MEM_CURRENT), 32'h21);
    watch_quiet(150, 18'h21, "inv_no_play");
    enable = 1'b0;
    cyc(1);

    // Enable dropped at bit 5 of a four-sample range
    AUD_ADDR1 = 18'h40;
    AUD_ADDR2 = 18'h44;
    enable    = 1'b1;
    wait_frame_start();
    collect(0, 5);
    enable = 1'b0;
    collect(6, 31);
    chk("drop_left", 32'(left_w), 32'h40BF);
    chk("drop_right", 32'(right_w), 32'h40BF);
    chk("drop_lrck", lr_w, 32'hFFFF0000);
    bclk_edge(1'b0);
    chk("drop_end_lrck", 32'(AUD_DACLRCK), 32'd1);
    chk("drop_end_dat", 32'(AUD_DACDAT), 32'd0);
    chk("drop_end_mem", 32'(MEM_CURRENT), 32'h41);
    chk("drop_end_done", 32'(done), 32'd0);
    watch_quiet(150, 18'h41, "drop_no_play");

    // Reset mid-frame at bit 20, then restart at 0x30
    AUD_ADDR1 = 18'h50;
    AUD_ADDR2 = 18'h54;
    enable    = 1'b1;
    cyc(1);
    chk("relatch_mem", 32'(MEM_CURRENT), 32'h50);
    wait_frame_start();
    collect(0, 20);
    chk("pre_rst_bclk", 32'(AUD_BCLK), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_bclk", 32'(AUD_BCLK), 32'd0);
    chk("arst_mem", 32'(MEM_CURRENT), 32'd0);
    chk("arst_lrck", 32'(AUD_DACLRCK), 32'd1);
    chk("arst_dat", 32'(AUD_DACDAT), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    enable = 1'b0;
    cyc(3);
    reset = 1'b1;
    level_len(1'b0, n);
    chk("arst_bclk_phase", 32'(n), 32'd24);
    AUD_ADDR1 = 18'h30;
    AUD_ADDR2 = 18'h31;
    enable    = 1'b1;
    cyc(1);
    chk("rs_mem_start", 32'(MEM_CURRENT), 32'h30);
    wait_frame_start();
    collect(0, 31);
    chk("rs_left", 32'(left_w), 32'h30CF);
    chk("rs_right", 32'(right_w), 32'h30CF);
    chk("rs_mem", 32'(MEM_CURRENT), 32'h31);
    bclk_edge(1'b0);
    chk("rs_done", 32'(done), 32'd1);
    enable = 1'b0;
    cyc(1);

    // Top of address space: no wrap past the end address
    AUD_ADDR1 = 18'h3FFFE;
    AUD_ADDR2 = 18'h3FFFF;
    enable    = 1'b1;
    wait_frame_start();
    collect(0, 31);
    chk("top_left", 32'(left_w), 32'hFE01);
    chk("top_right", 32'(right_w), 32'hFE01);
    chk("top_mem", 32'(MEM_CURRENT), 32'h3FFFF);
    bclk_edge(1'b0);
    chk("top_done", 32'(done), 32'd1);
    chk("top_end_mem", 32'(MEM_CURRENT), 32'h3FFFF);
    watch_quiet(150, 18'h3FFFF, "top_no_wrap");
    chk("top_done_hold", 32'(done), 32'd1);
    enable = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aud_out.md
AUD_OUT -- requirements
Module: aud_out

Interface
REQ-001 Parameter CLK_DIV, default 48, MCLK cycles per AUD_BCLK period (12.288 MHz / 48 = 256 kHz BCLK; 32 BCLK per frame = 8 kHz).
REQ-002 Parameter DATA_W, default 16, sample width in bits.
REQ-003 Parameter ADDR_W, default 18, memory address width.
REQ-004 MCLK  input  1  sole clock, rising-edge; all state updates on MCLK only.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  play request; level-sensitive.
REQ-007 AUD_ADDR1  input  ADDR_W  start address, inclusive.
REQ-008 AUD_ADDR2  input  ADDR_W  end address, exclusive.
REQ-009 MEM_CURRENT  output  ADDR_W  read address presented to sample memory.
REQ-010 MEM_DATA  input  DATA_W  sample read from MEM_CURRENT; valid at least 24 MCLK after MEM_CURRENT changes.
REQ-011 AUD_BCLK  output  1  bit clock to codec DAC.
REQ-012 AUD_DACLRCK  output  1  channel select; 0 = left slot, 1 = right slot.
REQ-013 AUD_DACDAT  output  1  serial sample data, MSB first.
REQ-014 done  output  1  range exhausted.

Function
REQ-015 clk_count SHALL count 0..CLK_DIV-1 free-running; AUD_BCLK SHALL be registered: 0 while clk_count < CLK_DIV/2, otherwise 1.
REQ-016 fall_tick SHALL be asserted when clk_count == CLK_DIV-1; on that edge AUD_BCLK goes low, and all serial-side updates SHALL occur on that same MCLK edge.
REQ-017 States: IDLE, READY, PLAY.
REQ-018 IDLE: on enable=1, latch addr <= AUD_ADDR1 and addr_e <= AUD_ADDR2, go to READY next MCLK; address inputs are ignored outside IDLE.
REQ-019 READY: on fall_tick with enable=1 and addr < addr_e, go to PLAY, load shift register from MEM_DATA, set addr <= addr+1, and set bit_cnt <= 0.
REQ-020 READY: on enable=0, return to IDLE on the next MCLK; a later enable re-latches the addresses.
REQ-021 PLAY: bit_cnt SHALL count 0..31 on each fall_tick; the frame holds a left slot (bit_cnt 0..15) and a right slot (bit_cnt 16..31).
REQ-022 PLAY: AUD_DACDAT SHALL equal sample bit (15 - bit_cnt mod 16), so the same sample is sent to both slots, left-justified, MSB in the first BCLK of each slot.
REQ-023 AUD_DACLRCK SHALL be 0 for bit_cnt 0..15 in PLAY and 1 otherwise; it changes only on fall_tick.
REQ-024 PLAY, fall_tick at bit_cnt == 31, enable=1 and addr < addr_e: load the next sample, increment addr, set bit_cnt <= 0, and stay in PLAY with no gap frame.
REQ-025 PLAY, fall_tick at bit_cnt == 31 otherwise: go to READY, set AUD_DACDAT=0 and AUD_DACLRCK=1.
REQ-026 Deasserting enable mid-frame SHALL NOT truncate the frame; the current frame completes first.
REQ-027 MEM_CURRENT SHALL equal addr combinationally; addr increments only on a sample load, so the next address is stable for a full frame before use.
REQ-028 done SHALL be (state == READY) & (addr == addr_e).
REQ-029 AUD_ADDR1 >= AUD_ADDR2: no PLAY entry and no increment; done is 1 only when equal; addr never wraps.
REQ-030 AUD_DACDAT SHALL be 0 outside PLAY.

Reset
REQ-031 While reset=0, all of the following SHALL hold: state=IDLE, clk_count=0, AUD_BCLK=0, AUD_DACLRCK=1, AUD_DACDAT=0, addr=0, addr_e=0, bit_cnt=0, shift register=0, done=0.
REQ-032 Reset asserted mid-frame SHALL abort immediately; after release the block restarts in IDLE with BCLK phase from clk_count=0.

Structure
REQ-033 CLK_DIV, slot/frame bit counts (16/32), and the state encoding SHALL live in shared package aud_pkg, also used by the capture path.
REQ-034 Sub-module aud_bclk_gen (clk_count, AUD_BCLK, fall_tick) SHALL be instantiated; it is reusable by the capture path.

Verification
REQ-035 Reset release, enable=0 -> AUD_BCLK period 48 MCLK (24 low/24 high), AUD_DACLRCK=1, AUD_DACDAT=0, done=0.
REQ-036 ADDR1=0x10, ADDR2=0x12, mem[0x10]=0xA5C3, mem[0x11]=0x0F0F, enable=1 -> two frames: left/right each serialise 1010010111000011 then 0000111100001111; MEM_CURRENT 0x10->0x11->0x12; then done=1, LRCK=1.
REQ-037 ADDR1=ADDR2=0x20, enable=1 -> no PLAY entry, MEM_CURRENT stays 0x20, done=1 one MCLK after READY entry; ADDR1=0x21, ADDR2=0x20 -> no PLAY entry, done=0.
REQ-038 Drop enable at bit_cnt=5 of the first of 4 frames -> frame completes through bit 31, then READY, then IDLE; MEM_CURRENT=start+1.
REQ-039 reset=0 at bit_cnt=20 -> outputs at reset values asynchronously; re-enable with ADDR1=0x30 -> playback restarts at 0x30.
REQ-040 ADDR2=0x3FFFF, ADDR1=0x3FFFE -> one frame, addr ends at 0x3FFFF, no wrap to 0, done=1.
